line_buffer_ctrl: RTL and testbench

Controller that sequences the four line buffers inside the spatial filter. It steers incoming pixels into one buffer at a time and starts a 3-line window read once three full lines are stored. It rotates buffer roles on each line boundary and raises an interrupt each time a buffer is freed for the next host line. It sits between the AXI-Stream slave input and the line-buffer/MAC datapath of `spatial_filter_top`.

---
 rtl/line_buffer_ctrl.sv | 138 +++++++++++++
 tb/tb_line_buffer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - write/read sequencer for the four spatial-filter line buffers
// Optional sticky drop flag o_overflow is enabled by LB_CTRL_OVERFLOW_FLAG_EN.
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512,
  parameter int NUM_LB      = 4
) (
  input  logic                      axis_clk,
  input  logic                      axis_reset,
  input  logic                      i_s_data_valid,
  output logic                      o_s_ready,
  output logic [NUM_LB-1:0]         o_lb_wr_en,
  input  logic                      i_m_ready,
  output logic [NUM_LB-1:0]         o_lb_rd_en,
  output logic [$clog2(NUM_LB)-1:0] o_rd_sel,
  output logic                      o_window_valid,
  output logic                      o_intr
`ifdef LB_CTRL_OVERFLOW_FLAG_EN
  ,
  output logic                      o_overflow
`endif
);

  localparam int              CNT_W        = $clog2(IMAGE_WIDTH);
  localparam int              SEL_W        = $clog2(NUM_LB);
  localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [2:0]      FILL_FULL    = 3'(NUM_LB);
  localparam logic [2:0]      WINDOW_LINES = 3'd3;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  rd_state_t          state, state_nxt;
  logic [CNT_W-1:0]   wr_pix_cnt, rd_pix_cnt;
  logic [SEL_W-1:0]   wr_sel, rd_sel;
  logic [2:0]         fill_cnt;
  logic [NUM_LB-1:0]  rd_mask;
  logic               wr_accept, wr_line_done;
  logic               rd_beat, rd_line_done;

  assign o_s_ready    = (fill_cnt < FILL_FULL);
  assign wr_accept    = i_s_data_valid && o_s_ready;
  assign wr_line_done = wr_accept && (wr_pix_cnt == PIX_LAST);
  assign o_lb_wr_en   = {{(NUM_LB-1){1'b0}}, wr_accept} << wr_sel;
  assign o_lb_rd_en   = rd_beat ? rd_mask : '0;
  assign o_rd_sel     = rd_sel;

  // The window is the three consecutive buffers starting at rd_sel, wrapping mod NUM_LB.
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < 3; i++) begin
      rd_mask[SEL_W'(rd_sel + SEL_W'(i))] = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_beat      = 1'b0;
    rd_line_done = 1'b0;
    case (state)
      IDLE: begin
        if (fill_cnt >= WINDOW_LINES) state_nxt = READ;
      end
      READ: begin
        if (i_m_ready) begin
          rd_beat = 1'b1;
          if (rd_pix_cnt == PIX_LAST) begin
            rd_line_done = 1'b1;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state          <= IDLE;
      wr_pix_cnt     <= '0;
      rd_pix_cnt     <= '0;
      wr_sel         <= '0;
      rd_sel         <= '0;
      fill_cnt       <= '0;
      o_window_valid <= 1'b0;
      o_intr         <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_window_valid <= rd_beat;
      o_intr         <= rd_line_done;

      if (wr_accept) begin
        if (wr_line_done) begin
          wr_pix_cnt <= '0;
          wr_sel     <= wr_sel + SEL_W'(1);
        end else begin
          wr_pix_cnt <= wr_pix_cnt + CNT_W'(1);
        end
      end

      if (rd_beat) begin
        if (rd_line_done) begin
          rd_pix_cnt <= '0;
          rd_sel     <= rd_sel + SEL_W'(1);
        end else begin
          rd_pix_cnt <= rd_pix_cnt + CNT_W'(1);
        end
      end

      // A line entering and a line leaving on the same edge cancel out.
      case ({wr_line_done, rd_line_done})
        2'b10:   fill_cnt <= fill_cnt + 3'd1;
        2'b01:   fill_cnt <= fill_cnt - 3'd1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

`ifdef LB_CTRL_OVERFLOW_FLAG_EN
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      o_overflow <= 1'b0;
    end else if (i_s_data_valid && !o_s_ready) begin
      o_overflow <= 1'b1;
    end
  end
`endif

  // The write pointer always leads the read pointer by exactly the stored line count,
  // which keeps the buffer being written out of the active window.
  a_sel_gap: assert property (@(posedge axis_clk) disable iff (axis_reset)
    SEL_W'(wr_sel - rd_sel) == fill_cnt[SEL_W-1:0]);

  a_fill_range: assert property (@(posedge axis_clk) disable iff (axis_reset)
    fill_cnt <= FILL_FULL);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - scoreboard bench for line_buffer_ctrl at IMAGE_WIDTH=8
module tb_line_buffer_ctrl;

  localparam int W = 8;

  logic       axis_clk = 1'b0;
  logic       axis_reset;
  logic       i_s_data_valid;
  logic       i_m_ready;
  logic       o_s_ready;
  logic [3:0] o_lb_wr_en;
  logic [3:0] o_lb_rd_en;
  logic [1:0] o_rd_sel;
  logic       o_window_valid;
  logic       o_intr;
`ifdef LB_CTRL_OVERFLOW_FLAG_EN
  logic       o_overflow;
`endif

  int passed = 0;
  int total  = 0;
  logic [3:0] rd_q[$];

  always #5 axis_clk = ~axis_clk;

  line_buffer_ctrl #(.IMAGE_WIDTH(W), .NUM_LB(4)) dut (
    .axis_clk       (axis_clk),
    .axis_reset     (axis_reset),
    .i_s_data_valid (i_s_data_valid),
    .o_s_ready      (o_s_ready),
    .o_lb_wr_en     (o_lb_wr_en),
    .i_m_ready      (i_m_ready),
    .o_lb_rd_en     (o_lb_rd_en),
    .o_rd_sel       (o_rd_sel),
    .o_window_valid (o_window_valid),
    .o_intr         (o_intr)
`ifdef LB_CTRL_OVERFLOW_FLAG_EN
    ,
    .o_overflow     (o_overflow)
`endif
  );

  task automatic cyc();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    axis_reset     = 1'b1;
    i_s_data_valid = 1'b0;
    i_m_ready      = 1'b0;
    rd_q.delete();
    repeat (3) cyc();
    axis_reset = 1'b0;
  endtask

  // Drives n contiguous pixels; pixel p of the stream belongs to line (first+p)/W.
  task automatic send_pixels(input int n, input int first, input logic mr);
    logic [3:0] want;
    for (int p = 0; p < n; p++) begin
      i_s_data_valid = 1'b1;
      i_m_ready      = mr;
      settle();
      want = 4'(1 << (((first + p) / W) % 4));
      total++;
      if (o_lb_wr_en !== want) $display("FAIL wr_en pixel %0d: got %b want %b", first + p, o_lb_wr_en, want);
      else passed++;
      cyc();
    end
    i_s_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send_pixels(13, 0, 1'b0);
    axis_reset = 1'b1;
    repeat (3) cyc();
    axis_reset = 1'b0;
    settle();
    total++; if (o_s_ready !== 1'b1) $display("FAIL reset s_ready: got %b want 1", o_s_ready); else passed++;
    total++; if (o_lb_wr_en !== 4'b0000) $display("FAIL reset wr_en: got %b want 0000", o_lb_wr_en); else passed++;
    total++; if (o_lb_rd_en !== 4'b0000) $display("FAIL reset rd_en: got %b want 0000", o_lb_rd_en); else passed++;
    total++; if (o_rd_sel !== 2'd0) $display("FAIL reset rd_sel: got %0d want 0", o_rd_sel); else passed++;
    total++; if (o_window_valid !== 1'b0) $display("FAIL reset window_valid: got %b want 0", o_window_valid); else passed++;
    total++; if (o_intr !== 1'b0) $display("FAIL reset intr: got %b want 0", o_intr); else passed++;
`ifdef LB_CTRL_OVERFLOW_FLAG_EN
    total++; if (o_overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", o_overflow); else passed++;
`endif
    // Stored partial line must be gone: the next 9 pixels start again in buffer 0.
    send_pixels(9, 0, 1'b0);
  endtask

  task automatic test_three_lines();
    logic [3:0] want;
    logic prev_beat = 1'b0;
    int first_beat = -1, beats = 0, intr_n = 0, intr_at = -1;
    do_reset();
    send_pixels(24, 0, 1'b1);
    repeat (W) rd_q.push_back(4'b0111);
    for (int k = 0; k < 20; k++) begin
      settle();
      if (o_lb_rd_en !== 4'b0000) begin
        beats++;
        if (first_beat < 0) first_beat = k;
        total++;
        if (rd_q.size() == 0) $display("FAIL three_lines extra read at %0d: got %b want 0000", k, o_lb_rd_en);
        else begin
          want = rd_q.pop_front();
          if (o_lb_rd_en !== want) $display("FAIL three_lines rd_en at %0d: got %b want %b", k, o_lb_rd_en, want);
          else passed++;
        end
      end
      total++;
      if (o_window_valid !== prev_beat) $display("FAIL three_lines window_valid at %0d: got %b want %b", k, o_window_valid, prev_beat);
      else passed++;
      prev_beat = (o_lb_rd_en !== 4'b0000);
      if (o_intr === 1'b1) begin
        intr_n++;
        intr_at = k;
      end
      cyc();
    end
    total++; if (first_beat !== 1) $display("FAIL three_lines first beat: got %0d want 1", first_beat); else passed++;
    total++; if (rd_q.size() !== 0) $display("FAIL three_lines beats left: got %0d want 0", rd_q.size()); else passed++;
    total++; if (intr_n !== 1) $display("FAIL three_lines intr count: got %0d want 1", intr_n); else passed++;
    total++; if (intr_at !== 9) $display("FAIL three_lines intr cycle: got %0d want 9", intr_at); else passed++;
    total++; if (o_rd_sel !== 2'd1) $display("FAIL three_lines rd_sel: got %0d want 1", o_rd_sel); else passed++;
  endtask

  task automatic test_full();
    logic [3:0] want;
    int intr_at = -1;
    do_reset();
    send_pixels(32, 0, 1'b0);
    settle();
    total++; if (o_s_ready !== 1'b0) $display("FAIL full s_ready: got %b want 0", o_s_ready); else passed++;
    i_s_data_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++; if (o_lb_wr_en !== 4'b0000) $display("FAIL full wr_en blocked %0d: got %b want 0000", k, o_lb_wr_en); else passed++;
      cyc();
    end
    i_m_ready = 1'b1;
    repeat (W) rd_q.push_back(4'b0111);
    for (int k = 0; k < 16 && intr_at < 0; k++) begin
      settle();
      if (o_intr === 1'b1) begin
        intr_at = k;
        total++; if (o_s_ready !== 1'b1) $display("FAIL full s_ready after intr: got %b want 1", o_s_ready); else passed++;
        total++; if (o_lb_wr_en !== 4'b0001) $display("FAIL full wr_en after intr: got %b want 0001", o_lb_wr_en); else passed++;
      end else begin
        total++; if (o_lb_wr_en !== 4'b0000) $display("FAIL full wr_en drain %0d: got %b want 0000", k, o_lb_wr_en); else passed++;
      end
      if (o_lb_rd_en !== 4'b0000) begin
        total++;
        if (rd_q.size() == 0) $display("FAIL full extra read at %0d: got %b want 0000", k, o_lb_rd_en);
        else begin
          want = rd_q.pop_front();
          if (o_lb_rd_en !== want) $display("FAIL full rd_en at %0d: got %b want %b", k, o_lb_rd_en, want);
          else passed++;
        end
      end
      cyc();
    end
    i_s_data_valid = 1'b0;
    i_m_ready      = 1'b0;
    total++; if (intr_at !== W) $display("FAIL full intr cycle: got %0d want %0d", intr_at, W); else passed++;
    total++; if (rd_q.size() !== 0) $display("FAIL full beats left: got %0d want 0", rd_q.size()); else passed++;
  endtask

  task automatic test_stall();
    logic [3:0] want;
    int beats = 0, last_beat = -1, intr_n = 0, intr_at = -1;
    do_reset();
    send_pixels(24, 0, 1'b0);
    cyc();
    repeat (W) rd_q.push_back(4'b0111);
    for (int k = 0; k < 20; k++) begin
      i_m_ready = ((k % 2) == 1);
      settle();
      total++;
      if (dut.rd_pix_cnt !== 3'(beats % W)) $display("FAIL stall rd_pix_cnt at %0d: got %0d want %0d", k, dut.rd_pix_cnt, beats % W);
      else passed++;
      if (!i_m_ready) begin
        total++; if (o_lb_rd_en !== 4'b0000) $display("FAIL stall rd_en held at %0d: got %b want 0000", k, o_lb_rd_en); else passed++;
      end else if (o_lb_rd_en !== 4'b0000) begin
        beats++;
        last_beat = k;
        total++;
        if (rd_q.size() == 0) $display("FAIL stall extra read at %0d: got %b want 0000", k, o_lb_rd_en);
        else begin
          want = rd_q.pop_front();
          if (o_lb_rd_en !== want) $display("FAIL stall rd_en at %0d: got %b want %b", k, o_lb_rd_en, want);
          else passed++;
        end
      end
      if (o_intr === 1'b1) begin
        intr_n++;
        intr_at = k;
      end
      cyc();
    end
    i_m_ready = 1'b0;
    total++; if (beats !== W) $display("FAIL stall beats: got %0d want %0d", beats, W); else passed++;
    total++; if (last_beat !== 15) $display("FAIL stall last beat: got %0d want 15", last_beat); else passed++;
    total++; if (intr_n !== 1) $display("FAIL stall intr count: got %0d want 1", intr_n); else passed++;
    total++; if (intr_at !== 16) $display("FAIL stall intr cycle: got %0d want 16", intr_at); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] want;
    do_reset();
    send_pixels(24, 0, 1'b0);
    cyc();
    repeat (W) rd_q.push_back(4'b0111);
    for (int k = 0; k < W; k++) begin
      i_s_data_valid = 1'b1;
      i_m_ready      = 1'b1;
      settle();
      total++; if (o_lb_wr_en !== 4'b1000) $display("FAIL simul wr_en at %0d: got %b want 1000", k, o_lb_wr_en); else passed++;
      total++;
      if (rd_q.size() == 0) $display("FAIL simul extra read at %0d: got %b want 0000", k, o_lb_rd_en);
      else begin
        want = rd_q.pop_front();
        if (o_lb_rd_en !== want) $display("FAIL simul rd_en at %0d: got %b want %b", k, o_lb_rd_en, want);
        else passed++;
      end
      cyc();
    end
    i_s_data_valid = 1'b0;
    settle();
    total++; if (o_intr !== 1'b1) $display("FAIL simul intr: got %b want 1", o_intr); else passed++;
    total++; if (o_lb_rd_en !== 4'b0000) $display("FAIL simul bubble rd_en: got %b want 0000", o_lb_rd_en); else passed++;
    total++; if (o_rd_sel !== 2'd1) $display("FAIL simul rd_sel: got %0d want 1", o_rd_sel); else passed++;
    total++; if (o_s_ready !== 1'b1) $display("FAIL simul s_ready: got %b want 1", o_s_ready); else passed++;
    cyc();
    settle();
    total++; if (o_lb_rd_en !== 4'b1110) $display("FAIL simul restart rd_en: got %b want 1110", o_lb_rd_en); else passed++;
    i_m_ready = 1'b0;
    i_s_data_valid = 1'b1;
    settle();
    total++; if (o_lb_wr_en !== 4'b0001) $display("FAIL simul next wr_en: got %b want 0001", o_lb_wr_en); else passed++;
    cyc();
    i_s_data_valid = 1'b0;
  endtask

`ifdef LB_CTRL_OVERFLOW_FLAG_EN
  task automatic test_overflow();
    do_reset();
    send_pixels(32, 0, 1'b0);
    settle();
    total++; if (o_overflow !== 1'b0) $display("FAIL overflow before drop: got %b want 0", o_overflow); else passed++;
    i_s_data_valid = 1'b1;
    cyc();
    i_s_data_valid = 1'b0;
    settle();
    total++; if (o_overflow !== 1'b1) $display("FAIL overflow set: got %b want 1", o_overflow); else passed++;
    i_m_ready = 1'b1;
    repeat (12) cyc();
    i_m_ready = 1'b0;
    settle();
    total++; if (o_s_ready !== 1'b1) $display("FAIL overflow drained s_ready: got %b want 1", o_s_ready); else passed++;
    total++; if (o_overflow !== 1'b1) $display("FAIL overflow sticky: got %b want 1", o_overflow); else passed++;
    do_reset();
    settle();
    total++; if (o_overflow !== 1'b0) $display("FAIL overflow cleared: got %b want 0", o_overflow); else passed++;
  endtask
`endif

  initial begin
    axis_reset     = 1'b1;
    i_s_data_valid = 1'b0;
    i_m_ready      = 1'b0;
    test_reset();
    test_three_lines();
    test_full();
    test_stall();
    test_simultaneous();
`ifdef LB_CTRL_OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
